// File: rtl/sound_sequencer.sv
// Fixed-priority buzzer scheduler: button tones, eat jingle and game-over jingle.
// Optional SOUND_MUTE_EN adds a mute input that silences tone_en/buzzer only.
module sound_sequencer #(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned NOTE_TICKS = 120
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  btn_num,
   input  logic        pressed,
   input  logic        eat_req,
   input  logic        game_over,
`ifdef SOUND_MUTE_EN
   input  logic        mute,
`endif
   output logic [14:0] frequency,
   output logic        tone_en,
   output logic        buzzer,
   output logic        busy
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned NW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [NW-1:0] NOTE_LAST  = NW'(NOTE_TICKS - 1);

   typedef enum logic [2:0] {StIdle, StBtn, StEat, StOver, StHold} state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [NW-1:0]   note_cnt_q, note_cnt_d;
   logic [1:0]      note_q, note_d;
   logic [14:0]     freq_d;
   logic [14:0]     hp_cnt_q;
   logic            tone_d;
   logic            in_jingle, tick, note_done, restart, mute_act;

`ifdef SOUND_MUTE_EN
   assign mute_act = mute;
`else
   assign mute_act = 1'b0;
`endif

   assign in_jingle = (state_q == StEat) || (state_q == StOver);
   assign tick      = in_jingle && (presc_q == PRESC_LAST);
   assign note_done = tick && (note_cnt_q == NOTE_LAST);

   always_comb begin
      state_d    = state_q;
      restart    = 1'b0;
      presc_d    = tick ? '0 : presc_q + 1'b1;
      note_cnt_d = note_done ? '0 : (tick ? note_cnt_q + 1'b1 : note_cnt_q);
      note_d     = note_done ? note_q + 2'd1 : note_q;

      if (game_over) begin
         if (state_q == StOver) begin
            if (note_done && note_q == 2'd3) state_d = StHold;
         end else if (state_q != StHold) begin
            state_d = StOver;
            restart = 1'b1;
         end
      end else if (state_q == StOver || state_q == StHold) begin
         state_d = StIdle;
      end else if (eat_req) begin
         state_d = StEat;
         restart = 1'b1;
      end else begin
         unique case (state_q)
            StIdle:  if (pressed) state_d = StBtn;
            StBtn:   if (!pressed) state_d = StIdle;
            StEat:   if (note_done && note_q == 2'd1) state_d = pressed ? StBtn : StIdle;
            default: ;
         endcase
      end

      // Counters only run inside a jingle and restart from zero on every entry.
      if (restart || !(state_d == StEat || state_d == StOver)) begin
         presc_d    = '0;
         note_cnt_d = '0;
         note_d     = '0;
      end
   end

   always_comb begin
      freq_d = 15'd0;
      case (state_d)
         StBtn: begin
            case (btn_num)
               2'd0: freq_d = 15'd25000;
               2'd1: freq_d = 15'd12500;
               2'd2: freq_d = 15'd8333;
               default: freq_d = 15'd6250;
            endcase
         end
         StEat: freq_d = (note_d == 2'd0) ? 15'd12500 : 15'd8333;
         StOver: begin
            case (note_d)
               2'd0: freq_d = 15'd6250;
               2'd1: freq_d = 15'd8333;
               2'd2: freq_d = 15'd12500;
               default: freq_d = 15'd25000;
            endcase
         end
         default: freq_d = 15'd0;
      endcase
      tone_d = (state_d == StBtn || state_d == StEat || state_d == StOver) && !mute_act;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         note_cnt_q <= '0;
         note_q     <= '0;
         frequency  <= '0;
         tone_en    <= 1'b0;
         busy       <= 1'b0;
         hp_cnt_q   <= '0;
         buzzer     <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         note_cnt_q <= note_cnt_d;
         note_q     <= note_d;
         frequency  <= freq_d;
         tone_en    <= tone_d;
         busy       <= (state_d != StIdle);
         // A new note or a tone (re)start begins with a clean low half-period.
         if (!tone_d || !tone_en || freq_d != frequency) begin
            hp_cnt_q <= '0;
            buzzer   <= 1'b0;
         end else if (hp_cnt_q == frequency - 15'd1) begin
            hp_cnt_q <= '0;
            buzzer   <= ~buzzer;
         end else begin
            hp_cnt_q <= hp_cnt_q + 15'd1;
         end
      end
   end

endmodule

// File: doc/sound_sequencer.md
Name: sound_sequencer

Overview:
- Schedules the game's single buzzer between three sound sources: direction-button tones, pellet-eaten jingle and game-over jingle.
- Arbitrates by fixed priority, steps multi-note jingles on a millisecond tick, and drives both the half-period code (frequency) and the square-wave buzzer pin.
- Sits between game logic / input debouncers and the board buzzer output.

Parameters:
- TICK_DIV, 50000, clk cycles per sequencer tick (1 ms at 50 MHz).
- NOTE_TICKS, 120, ticks per jingle note.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_num  in  2  index of the pressed direction button.
- pressed  in  1  level; a direction button is held.
- eat_req  in  1  single-cycle pulse; pellet eaten.
- game_over  in  1  level; game ended.
- frequency  out  15  half-period in clk cycles of the current note; 0 when silent.
- tone_en  out  1  buzzer active.
- buzzer  out  1  square-wave output.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE; frequency=0, tone_en=0, buzzer=0, busy=0; all counters 0. Effective mid-jingle, with no residual tone.
- All outputs are registered. A request sampled at edge N gives the new state, frequency and tone_en at N+1.
- States and priority:
  - OVER (highest) > EAT > BTN > IDLE.
  - game_over=1 forces OVER from any state.
  - eat_req forces EAT from IDLE or BTN.
  - pressed=1 enters BTN from IDLE only.
- BTN:
  - tone_en=1; frequency per btn_num: 0→25000, 1→12500, 2→8333, 3→6250.
  - A btn_num change updates frequency on the next cycle.
  - pressed=0 → IDLE next cycle.
- EAT:
  - Notes 12500 then 8333, each NOTE_TICKS ticks; then IDLE, or BTN if pressed=1.
  - eat_req during EAT restarts at note 0 with fresh timing.
- OVER:
  - Notes 6250, 8333, 12500, 25000, each NOTE_TICKS ticks.
  - Then HOLD: tone_en=0, frequency=0, busy=1.
  - game_over=0 in OVER or HOLD → IDLE next cycle.
- Tick prescaler:
  - Counts 0..TICK_DIV-1; tick pulses at the terminal count.
  - Cleared on every jingle entry or restart, so each note lasts exactly NOTE_TICKS*TICK_DIV cycles.
  - Note index advances on tick when note_cnt==NOTE_TICKS-1.
- Buzzer generator:
  - hp_cnt counts 0..frequency-1; buzzer toggles and hp_cnt clears at the terminal count.
  - On any frequency change or tone_en rise, hp_cnt=0 and buzzer=0.
  - tone_en=0 → buzzer held 0, hp_cnt=0.
- Simultaneous events:
  - game_over with eat_req → OVER.
  - eat_req with a pressed rise in IDLE → EAT.
  - eat_req on the same cycle EAT finishes → restart EAT.
- Widths:
  - frequency 15 bits; every note value is < 32768.
  - hp_cnt is 15 bits; prescaler and note counters are sized by $clog2 of their parameters.

Optional Feature:
- Macro SOUND_MUTE_EN.
- Defined: adds input port mute (1 bit). While mute=1, tone_en and buzzer are forced 0. Sequencing, frequency and busy continue unchanged. Releasing mute resumes the tone with hp_cnt=0.
- Undefined: no mute port; behaviour exactly as above.

Test Plan (TICK_DIV=4, NOTE_TICKS=3, so 12 cycles per note):
- Reset mid-EAT (rst_n low for 1 cycle) → frequency=0, tone_en=0, buzzer=0, busy=0 immediately; IDLE after release.
- pressed=1 with btn_num=2 → frequency=8333 and tone_en=1 one cycle later; btn_num→0 gives 25000 next cycle; pressed=0 → IDLE and frequency=0 next cycle.
- eat_req pulse in IDLE → 12500 for 12 cycles, 8333 for 12 cycles, then busy=0. Second eat_req at cycle 18 → 12500 restarts for a full 12 cycles.
- pressed=1 held, then eat_req → EAT preempts; after the jingle, returns to BTN with the button frequency.
- game_over=1 during EAT → 6250/8333/12500/25000 at 12 cycles each, then tone_en=0 with busy=1; game_over=0 → IDLE next cycle.
- Force frequency=4 via a short test note (override) → buzzer toggles every 4 cycles (period 8). SOUND_MUTE_EN build with mute=1 → buzzer stays 0 while frequency still steps.
